// File: rtl/pipe_addn_if.sv
// Handshake bus for pipe_addn.
//   master : operand producer and result consumer (drives in_valid, a, b, cin, sub, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, cout, ovf)
interface pipe_addn_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_addn.sv
// pipe_addn: segmented, fully pipelined add/subtract unit.
// Each of the WIDTH/SEG stages adds one SEG-bit slice and registers the slice
// carry for the next stage. Operands (with B already inverted for subtract)
// travel alongside so every stage sees the original operand slices.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pipe_addn_if.slave: in_valid/in_ready/a/b/cin/sub on the input side,
//          out_valid/out_ready/sum/cout/ovf on the output side
module pipe_addn #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_addn_if.slave  bus
);
  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];

  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_out [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [SEG:0]     w_seg   [STAGES];
  logic             w_stall;

  // A stall freezes the whole pipe; no partial advance into empty slots.
  assign w_stall = r_v[LAST] & ~bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is a + ~b + ~cin, so invert B and the carry-in up front.
      assign w_a_in[k] = bus.a;
      assign w_b_in[k] = bus.sub ? ~bus.b : bus.b;
      assign w_c_in[k] = bus.cin ^ bus.sub;
      assign w_s_in[k] = '0;
      assign w_v_in[k] = bus.in_valid;
    end else begin : g_next
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_v_in[k] = r_v[k-1];
    end

    assign w_seg[k] = {1'b0, w_a_in[k][k*SEG +: SEG]}
                    + {1'b0, w_b_in[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, w_c_in[k]};

    // Slices above k are still zero in w_s_in, so OR inserts this slice.
    assign w_s_out[k] = w_s_in[k] | (WIDTH'(w_seg[k][SEG-1:0]) << (k*SEG));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_out[k];
        r_c[k] <= w_seg[k][SEG];
        r_v[k] <= w_v_in[k];
      end
    end
  end

  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_v[LAST];
  assign bus.sum       = r_s[LAST];
  assign bus.cout      = r_c[LAST];
  // Overflow uses the effective B operand carried to the last stage.
  assign bus.ovf       = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1])
                       & (r_s[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipe_addn.sv
module tb_pipe_addn;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_addn_if #(.WIDTH(16)) bus ();

  pipe_addn #(.WIDTH(16), .SEG(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // backpressure vectors, sums worked out by hand
  logic [15:0] bp_a    [6] = '{16'h1234, 16'hF00F, 16'h8001, 16'h0FFF, 16'hAAAA, 16'h7FFF};
  logic [15:0] bp_b    [6] = '{16'h1111, 16'h0FF1, 16'h8001, 16'h0001, 16'h5556, 16'h7FFF};
  logic [15:0] bp_sum  [6] = '{16'h2345, 16'h0000, 16'h0002, 16'h1000, 16'h0000, 16'hFFFE};
  logic        bp_cout [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        bp_ovf  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    n_checks++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_sweep();
    logic        exp_v;
    logic [15:0] exp_s;
    for (int cyc = 0; cyc <= 21; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 4 && cyc <= 20);
      n_checks++; if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL sweep_valid cyc%0d: got %b want %b", cyc, bus.out_valid, exp_v); end
      if (exp_v) begin
        exp_s = 16'h000C + 16'(cyc - 4);
        n_checks++; if (bus.sum !== exp_s) begin n_fail++; $display("FAIL sweep_sum cyc%0d: got %h want %h", cyc, bus.sum, exp_s); end
        n_checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL sweep_flags cyc%0d: got cout=%b ovf=%b want 0 0", cyc, bus.cout, bus.ovf); end
      end
      if (cyc <= 16) begin
        bus.in_valid = 1'b1; bus.a = 16'h000B; bus.b = 16'(cyc); bus.cin = 1'b1; bus.sub = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  // Sends one operand set and reports the first result and its latency (99 = never seen).
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         output logic [15:0] s, output logic c, output logic o, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    lat = 0; s = 'x; c = 1'bx; o = 1'bx;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        lat = i; s = bus.sum; c = bus.cout; o = bus.ovf;
      end
    end
    if (lat == 0) lat = 99;
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, o; int lat;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL carry1_latency: got %0d want 4", lat); end
    n_checks++; if (s !== 16'h0000 || c !== 1'b1 || o !== 1'b0) begin n_fail++; $display("FAIL carry1_result: got %h c=%b v=%b want 0000 c=1 v=0", s, c, o); end
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL carry2_latency: got %0d want 4", lat); end
    n_checks++; if (s !== 16'h8000 || c !== 1'b0 || o !== 1'b1) begin n_fail++; $display("FAIL carry2_result: got %h c=%b v=%b want 8000 c=0 v=1", s, c, o); end
  endtask

  task automatic test_subtract();
    logic [15:0] s; logic c, o; int lat;
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, o, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL sub1_latency: got %0d want 4", lat); end
    n_checks++; if (s !== 16'hFFFE || c !== 1'b0 || o !== 1'b0) begin n_fail++; $display("FAIL sub1_result: got %h c=%b v=%b want FFFE c=0 v=0", s, c, o); end
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL sub2_latency: got %0d want 4", lat); end
    n_checks++; if (s !== 16'h7FFF || c !== 1'b1 || o !== 1'b1) begin n_fail++; $display("FAIL sub2_result: got %h c=%b v=%b want 7FFF c=1 v=1", s, c, o); end
    // borrow-in: 0x0010 - 0x0003 - 1 = 0x000C, no borrow out
    run_one(16'h0010, 16'h0003, 1'b1, 1'b1, s, c, o, lat);
    n_checks++; if (s !== 16'h000C || c !== 1'b1 || o !== 1'b0) begin n_fail++; $display("FAIL sub3_result: got %h c=%b v=%b want 000C c=1 v=0", s, c, o); end
  endtask

  task automatic test_backpressure();
    int idx_in = 0, idx_out = 0, stall_cnt = 0;
    logic stalled_prev = 1'b0;
    logic [15:0] held_s; logic held_c, held_o;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && idx_out < 6; cyc++) begin
      if (cyc != 0) @(negedge clk);
      bus.out_ready = !(bus.out_valid === 1'b1 && stall_cnt < 3);
      if (!bus.out_ready) stall_cnt++;
      bus.in_valid = (idx_in < 6);
      if (idx_in < 6) begin
        bus.a = bp_a[idx_in]; bus.b = bp_b[idx_in]; bus.cin = 1'b0; bus.sub = 1'b0;
      end
      #1;
      if (!bus.out_ready) begin
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, bus.in_ready); end
        if (stalled_prev) begin
          n_checks++;
          if (bus.sum !== held_s || bus.cout !== held_c || bus.ovf !== held_o) begin
            n_fail++; $display("FAIL bp_hold cyc%0d: got %h/%b/%b want %h/%b/%b", cyc, bus.sum, bus.cout, bus.ovf, held_s, held_c, held_o);
          end
        end
        held_s = bus.sum; held_c = bus.cout; held_o = bus.ovf;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        n_checks++;
        if (bus.sum !== bp_sum[idx_out] || bus.cout !== bp_cout[idx_out] || bus.ovf !== bp_ovf[idx_out]) begin
          n_fail++; $display("FAIL bp_result%0d: got %h c=%b v=%b want %h c=%b v=%b", idx_out, bus.sum, bus.cout, bus.ovf, bp_sum[idx_out], bp_cout[idx_out], bp_ovf[idx_out]);
        end
        idx_out++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) idx_in++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_checks++; if (idx_out != 6) begin n_fail++; $display("FAIL bp_count: got %0d results want 6", idx_out); end
    n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", stall_cnt); end
    repeat (6) begin
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_result: got out_valid=%b want 0", bus.out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 16'h0100; bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0;
    @(negedge clk); bus.a = 16'h0200;
    @(negedge clk); bus.a = 16'h0300;
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got out_valid=%b want 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL mid_async_outputs: got %h/%b/%b want 0000/0/0", bus.sum, bus.cout, bus.ovf); end
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc%0d: got out_valid=%b want 0", i, bus.out_valid); end
    end
    bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b1; bus.sub = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== (i == 4)) begin n_fail++; $display("FAIL mid_new_valid cyc%0d: got %b want %b", i, bus.out_valid, (i == 4)); end
      if (i == 4) begin
        n_checks++; if (bus.sum !== 16'h2346 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL mid_new_result: got %h c=%b v=%b want 2346 c=0 v=0", bus.sum, bus.cout, bus.ovf); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_carry();
    test_subtract();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
